spi_sck_mode_ctrl: RTL and testbench

Parametrised SPI clock and mode controller, the successor to the fixed master/slave strobe selector. In master mode it generates SCK from a programmable divider; in slave mode it synchronises the pad SCK/SS_n. In both modes it emits one-cycle shift/sample strobes according to CPOL/CPHA and counts bits to a programmable frame length. It sits between the register block and the shift-register datapath.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_sync_edge.sv | 27 ++
 rtl/spi_sck_mode_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_spi_sck_mode_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI clock/mode controller.
package spi_pkg;

  localparam int unsigned DEF_DIV_W   = 8;
  localparam int unsigned DEF_FRAME_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RUN,
    ST_GUARD
  } state_e;

  // {cpol, cpha} encodings
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // True when the leading SCK edge is the sample edge (CPHA=0 modes).
  function automatic logic lead_samples(input logic [1:0] mode);
    return (mode == SPI_MODE0) || (mode == SPI_MODE2);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pad input with rise/fall detection.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_c,
  output logic fall_c
);

  // Top bit is the previous synchronised value, used only for edge detection.
  logic [STAGES:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {(STAGES + 1){RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-1:0], async_i};
    end
  end

  assign rise_c =  sync_q[STAGES-1] & ~sync_q[STAGES];
  assign fall_c = ~sync_q[STAGES-1] &  sync_q[STAGES];

endmodule

// File: rtl/spi_sck_mode_ctrl.sv
// SPI SCK generator (master) / SCK follower (slave) issuing CPOL/CPHA shift and
// sample strobes and counting bits to a programmable frame length.
module spi_sck_mode_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W       = DEF_DIV_W,
  parameter int unsigned FRAME_W     = DEF_FRAME_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mstr,
  input  logic               cpol,
  input  logic               cpha,
  input  logic [DIV_W-1:0]   div,
  input  logic [FRAME_W-1:0] frame_len,
  input  logic               start,
  input  logic               sck_in,
  input  logic               ss_n_in,
  output logic               sck_out,
  output logic               sck_oe,
  output logic               shift_stb,
  output logic               sample_stb,
  output logic               busy,
  output logic               done,
  output logic               abort,
  output logic [FRAME_W-1:0] bit_cnt
);

  // Edge counter must reach 2*(2^FRAME_W) in master mode.
  localparam int unsigned EW = FRAME_W + 2;

  state_e             state_q;
  logic               mst_q, cpol_q, cpha_q;
  logic [DIV_W-1:0]   div_q, cnt_q;
  logic [FRAME_W-1:0] flen_q, bit_cnt_q;
  logic [EW-1:0]      edge_q;
  logic               sck_q, oe_q, shift_q, sample_q, busy_q, done_q, abort_q;

  logic sck_rise, sck_fall, ss_rise, ss_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk    (clk),
    .rst    (rst),
    .async_i(sck_in),
    .rise_c (sck_rise),
    .fall_c (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk    (clk),
    .rst    (rst),
    .async_i(ss_n_in),
    .rise_c (ss_rise),
    .fall_c (ss_fall)
  );

  logic          lead_smp, s_lead, s_trail, s_smp, s_shf, s_fin;
  logic [EW-1:0] edge_nxt, last_edge;

  assign lead_smp  = lead_samples({cpol_q, cpha_q});
  assign edge_nxt  = edge_q + EW'(1);
  assign last_edge = (EW'(flen_q) << 1) + EW'(2);
  assign s_lead    = cpol_q ? sck_fall : sck_rise;
  assign s_trail   = cpol_q ? sck_rise : sck_fall;
  assign s_smp     = lead_smp ? s_lead  : s_trail;
  assign s_shf     = lead_smp ? s_trail : s_lead;
  // Slave: edge_q counts samples; once it exceeds frame_len the frame is complete.
  assign s_fin     = edge_q > EW'(flen_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mst_q     <= 1'b0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      div_q     <= '0;
      cnt_q     <= '0;
      flen_q    <= '0;
      edge_q    <= '0;
      bit_cnt_q <= '0;
      sck_q     <= 1'b0;
      oe_q      <= 1'b0;
      shift_q   <= 1'b0;
      sample_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      shift_q  <= 1'b0;
      sample_q <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      if (sample_q) bit_cnt_q <= bit_cnt_q + FRAME_W'(1);

      case (state_q)
        ST_IDLE: begin
          sck_q <= cpol;
          oe_q  <= mstr;
          if ((mstr && start) || (!mstr && ss_fall)) begin
            cpol_q    <= cpol;
            cpha_q    <= cpha;
            div_q     <= div;
            flen_q    <= frame_len;
            mst_q     <= mstr;
            cnt_q     <= div;
            edge_q    <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= mstr ? ST_SETUP : ST_RUN;
          end
        end

        ST_SETUP: begin
          if (cnt_q == '0) begin
            cnt_q   <= div_q;
            sck_q   <= ~sck_q;
            edge_q  <= EW'(1);
            state_q <= ST_RUN;
            if (lead_smp) sample_q <= 1'b1;
            else          shift_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end

        ST_RUN: begin
          if (mst_q) begin
            if (cnt_q == '0) begin
              cnt_q  <= div_q;
              sck_q  <= ~sck_q;
              edge_q <= edge_nxt;
              // Odd edges are leading; the trailing shift after the last sample is dropped.
              if (edge_nxt[0]) begin
                if (lead_smp) sample_q <= 1'b1;
                else          shift_q  <= 1'b1;
              end else if (!lead_smp) begin
                sample_q <= 1'b1;
              end else if (edge_nxt != last_edge) begin
                shift_q <= 1'b1;
              end
              if (edge_nxt == last_edge) state_q <= ST_GUARD;
            end else begin
              cnt_q <= cnt_q - DIV_W'(1);
            end
          end else begin
            if (ss_rise) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
              if (!s_fin) begin
                abort_q   <= 1'b1;
                bit_cnt_q <= '0;
              end
            end else if (!s_fin && s_smp) begin
              sample_q <= 1'b1;
              edge_q   <= edge_nxt;
              if (edge_q == EW'(flen_q)) done_q <= 1'b1;
            end else if (!s_fin && s_shf) begin
              shift_q <= 1'b1;
            end
          end
        end

        ST_GUARD: begin
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sck_out    = sck_q;
  assign sck_oe     = oe_q;
  assign shift_stb  = shift_q;
  assign sample_stb = sample_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign abort      = abort_q;
  assign bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_spi_sck_mode_ctrl.sv
// Bench for spi_sck_mode_ctrl: directed and random master/slave frames against a
// cycle-schedule reference derived from the edge/strobe rules.
module tb_spi_sck_mode_ctrl;
  import spi_pkg::*;

  localparam int unsigned DIV_W   = 8;
  localparam int unsigned FRAME_W = 4;
  localparam int          HP      = 8;   // slave pad half-period in clk cycles
  localparam int          FE      = 12;  // first slave pad SCK edge cycle

  logic               clk = 1'b0;
  logic               rst, mstr, cpol, cpha, start, sck_in, ss_n_in;
  logic [DIV_W-1:0]   div;
  logic [FRAME_W-1:0] frame_len;
  logic               sck_out, sck_oe, shift_stb, sample_stb, busy, done, abort;
  logic [FRAME_W-1:0] bit_cnt;

  int checks = 0;
  int errors = 0;
  int o_tog, o_shift, o_sample, o_shift_fall, o_done_cnt, o_abort_cnt;
  int o_done_t, o_first_sample_t, o_first_tog_t, o_first_shift_t;
  logic [1:0] lm;

  spi_sck_mode_ctrl #(.DIV_W(DIV_W), .FRAME_W(FRAME_W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .mstr      (mstr),
    .cpol      (cpol),
    .cpha      (cpha),
    .div       (div),
    .frame_len (frame_len),
    .start     (start),
    .sck_in    (sck_in),
    .ss_n_in   (ss_n_in),
    .sck_out   (sck_out),
    .sck_oe    (sck_oe),
    .shift_stb (shift_stb),
    .sample_stb(sample_stb),
    .busy      (busy),
    .done      (done),
    .abort     (abort),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_obs();
    o_tog = 0; o_shift = 0; o_sample = 0; o_shift_fall = 0; o_done_cnt = 0; o_abort_cnt = 0;
    o_done_t = -1; o_first_sample_t = -1; o_first_tog_t = -1; o_first_shift_t = -1;
  endtask

  task automatic observe(input int t, input logic prev_sck);
    if (sck_out !== prev_sck) begin
      o_tog++;
      if (o_first_tog_t < 0) o_first_tog_t = t;
    end
    if (shift_stb === 1'b1) begin
      o_shift++;
      if (sck_out === 1'b0) o_shift_fall++;
      if (o_first_shift_t < 0) o_first_shift_t = t;
    end
    if (sample_stb === 1'b1) begin
      o_sample++;
      if (o_first_sample_t < 0) o_first_sample_t = t;
    end
    if (done === 1'b1) begin
      o_done_cnt++;
      o_done_t = t;
    end
    if (abort === 1'b1) o_abort_cnt++;
  endtask

  // Master frame: edge i at cycle i*H, done at (2N+1)*H, cycle 0 = first cycle busy is high.
  task automatic master_frame(input logic pol, input logic pha, input int dv, input int fl,
                              input bit perturb);
    int h, n, tend, acc, e, ec;
    bit edge_now, lead, s_exp, sh_exp;
    logic exp_sck, prev_sck;
    h = dv + 1; n = fl + 1; tend = (2 * n + 1) * h;
    @(negedge clk);
    mstr = 1'b1; cpol = pol; cpha = pha; div = DIV_W'(dv); frame_len = FRAME_W'(fl);
    @(negedge clk);
    chk("m_idle_sck", 32'(sck_out), 32'(pol));
    chk("m_idle_oe", 32'(sck_oe), 32'd1);
    chk("m_idle_busy", 32'(busy), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clr_obs();
    acc = 0; prev_sck = pol;
    for (int t = 0; t <= tend; t++) begin
      e        = t / h;
      ec       = (e > 2 * n) ? 2 * n : e;
      edge_now = (t % h == 0) && (e >= 1) && (e <= 2 * n);
      lead     = (e % 2) == 1;
      s_exp    = edge_now && (pha ? !lead : lead);
      sh_exp   = edge_now && (pha ? lead : (!lead && e != 2 * n));
      exp_sck  = (ec % 2 == 1) ? ~pol : pol;
      chk("m_sck", 32'(sck_out), 32'(exp_sck));
      chk("m_sample", 32'(sample_stb), 32'(s_exp));
      chk("m_shift", 32'(shift_stb), 32'(sh_exp));
      chk("m_busy", 32'(busy), 32'(t < tend));
      chk("m_done", 32'(done), 32'(t == tend));
      chk("m_abort", 32'(abort), 32'd0);
      chk("m_oe", 32'(sck_oe), 32'd1);
      chk("m_bitcnt", 32'(bit_cnt), 32'(acc % 16));
      observe(t, prev_sck);
      prev_sck = sck_out;
      if (s_exp) acc++;
      if (perturb && t == 3) begin
        start = 1'b1; cpol = ~pol; cpha = ~pha; mstr = 1'b0;
        div = DIV_W'(dv + 3); frame_len = FRAME_W'(fl + 2);
      end
      if (perturb && t == 4) start = 1'b0;
      @(negedge clk);
    end
    if (perturb) begin
      mstr = 1'b1; cpol = pol; cpha = pha; div = DIV_W'(dv); frame_len = FRAME_W'(fl);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("m_no_requeue", 32'(busy), 32'd0);
      end
    end
  endtask

  // Slave frame: k bits clocked on the pad at clk/16; strobes expected 3 cycles after pad edges.
  task automatic slave_frame(input logic pol, input logic pha, input int fl, input int k);
    bit es_sh[256], es_sm[256], es_dn[256], es_ab[256];
    int n, r, tl, smp, c, acc, nle;
    bit lead, is_s, aborted;
    logic prev_sck;
    n = fl + 1;
    r = FE + (2 * k - 1) * HP + HP;
    tl = r + 8;
    for (int i = 0; i < 256; i++) begin
      es_sh[i] = 1'b0; es_sm[i] = 1'b0; es_dn[i] = 1'b0; es_ab[i] = 1'b0;
    end
    smp = 0;
    for (int j = 1; j <= 2 * k; j++) begin
      c    = FE + (j - 1) * HP + 3;
      lead = (j % 2) == 1;
      is_s = pha ? !lead : lead;
      if (smp < n) begin
        if (is_s) begin
          es_sm[c] = 1'b1;
          smp++;
          if (smp == n) es_dn[c] = 1'b1;
        end else begin
          es_sh[c] = 1'b1;
        end
      end
    end
    aborted = smp < n;
    if (aborted) es_ab[r + 3] = 1'b1;

    @(negedge clk);
    mstr = 1'b0; cpol = pol; cpha = pha; frame_len = FRAME_W'(fl); sck_in = pol; ss_n_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("s_idle_oe", 32'(sck_oe), 32'd0);
    chk("s_idle_busy", 32'(busy), 32'd0);
    clr_obs();
    acc = 0; prev_sck = sck_out;
    for (int t = 0; t <= tl; t++) begin
      chk("s_shift", 32'(shift_stb), 32'(es_sh[t]));
      chk("s_sample", 32'(sample_stb), 32'(es_sm[t]));
      chk("s_done", 32'(done), 32'(es_dn[t]));
      chk("s_abort", 32'(abort), 32'(es_ab[t]));
      chk("s_busy", 32'(busy), 32'(t >= 7 && t < r + 3));
      chk("s_sck", 32'(sck_out), 32'(pol));
      chk("s_oe", 32'(sck_oe), 32'd0);
      if (t >= 7) chk("s_bitcnt", 32'(bit_cnt), (aborted && t >= r + 3) ? 32'd0 : 32'(acc % 16));
      observe(t, prev_sck);
      prev_sck = sck_out;
      if (es_sm[t]) acc++;
      nle = (t < FE) ? 0 : ((t - FE) / HP + 1);
      if (nle > 2 * k) nle = 2 * k;
      sck_in  = (nle % 2 == 1) ? ~pol : pol;
      ss_n_in = !(t >= 4 && t < r);
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; mstr = 1'b0; cpol = 1'b0; cpha = 1'b0; div = '0; frame_len = '0;
    start = 1'b0; sck_in = 1'b0; ss_n_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sck", 32'(sck_out), 32'd0);
    chk("rst_oe", 32'(sck_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({shift_stb, sample_stb, done, abort}), 32'd0);
    chk("rst_bitcnt", 32'(bit_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Mode 0, div=1, 8 bits
    master_frame(1'b0, 1'b0, 1, 7, 1'b0);
    chk("d0_toggles", 32'(o_tog), 32'd16);
    chk("d0_shifts", 32'(o_shift), 32'd7);
    chk("d0_samples", 32'(o_sample), 32'd8);
    chk("d0_first_sample", 32'(o_first_sample_t), 32'd2);
    chk("d0_first_toggle", 32'(o_first_tog_t), 32'd2);
    chk("d0_done_cycle", 32'(o_done_t), 32'd34);
    chk("d0_bitcnt_end", 32'(bit_cnt), 32'd8);

    // Mode 3, div=0, 4 bits
    lm = SPI_MODE3;
    master_frame(lm[1], lm[0], 0, 3, 1'b0);
    chk("d3_shifts", 32'(o_shift), 32'd4);
    chk("d3_samples", 32'(o_sample), 32'd4);
    chk("d3_shift_on_fall", 32'(o_shift_fall), 32'd4);
    chk("d3_done_cycle", 32'(o_done_t), 32'd9);

    // Start and setting changes mid-frame are ignored
    master_frame(1'b0, 1'b0, 1, 5, 1'b1);
    chk("dp_done_cycle", 32'(o_done_t), 32'd26);
    chk("dp_done_count", 32'(o_done_cnt), 32'd1);

    // Async reset at edge 5
    @(negedge clk);
    mstr = 1'b1; cpol = 1'b0; cpha = 1'b0; div = DIV_W'(1); frame_len = FRAME_W'(7);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("r_pre_busy", 32'(busy), 32'd1);
    chk("r_pre_sample", 32'(sample_stb), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("r_async_sck", 32'(sck_out), 32'd0);
    chk("r_async_oe", 32'(sck_oe), 32'd0);
    chk("r_async_busy", 32'(busy), 32'd0);
    chk("r_async_strobes", 32'({shift_stb, sample_stb, done, abort}), 32'd0);
    chk("r_async_bitcnt", 32'(bit_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    master_frame(1'b0, 1'b0, 1, 7, 1'b0);
    chk("r_clean_done", 32'(o_done_t), 32'd34);

    // Slave, mode 1, 8 bits, complete frame
    lm = SPI_MODE1;
    slave_frame(lm[1], lm[0], 7, 8);
    chk("s1_samples", 32'(o_sample), 32'd8);
    chk("s1_first_shift", 32'(o_first_shift_t), 32'd15);
    chk("s1_done_at_8th", 32'(o_done_t), 32'd135);
    chk("s1_done_count", 32'(o_done_cnt), 32'd1);
    chk("s1_bitcnt_end", 32'(bit_cnt), 32'd8);

    // Slave abort after 5 samples
    slave_frame(1'b0, 1'b0, 7, 5);
    chk("sa_abort_count", 32'(o_abort_cnt), 32'd1);
    chk("sa_done_count", 32'(o_done_cnt), 32'd0);
    chk("sa_bitcnt", 32'(bit_cnt), 32'd0);
    chk("sa_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 12; i++) begin
      master_frame(1'($urandom_range(1)), 1'($urandom_range(1)),
                   int'($urandom_range(3)), int'($urandom_range(15)), 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      int fl;
      fl = int'($urandom_range(7));
      slave_frame(1'($urandom_range(1)), 1'($urandom_range(1)), fl,
                  int'($urandom_range(fl + 1, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
